// File: rtl/adc_pair_packer.sv
`default_nettype none
// ============================================================================
// Module   : adc_pair_packer
// Brief    : Pairs channel-A/channel-B ADC conversions, decimates, and emits
//            packed 32-bit words {4'h0, chB, 4'h0, chA} for sample storage.
// Revision : 1.0 - initial release
// ============================================================================
module adc_pair_packer #(
    parameter int CH_A    = 1,
    parameter int CH_B    = 2,
    parameter int DECIM_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [DECIM_W-1:0] decim,
    input  logic               adc_valid,
    input  logic [4:0]         adc_channel,
    input  logic [11:0]        adc_data,
    output logic               sample_valid,
    output logic [31:0]        sample_data,
    output logic [15:0]        orphan_cnt,
    output logic [31:0]        pair_cnt
);

    localparam logic [4:0]         c_ch_a      = 5'(CH_A);
    localparam logic [4:0]         c_ch_b      = 5'(CH_B);
    localparam logic [DECIM_W-1:0] c_decim_one = DECIM_W'(1);

    typedef enum logic [0:0] {
        S_WAIT_A = 1'b0,
        S_WAIT_B = 1'b1
    } state_t;

    state_t             r_state;
    logic [11:0]        r_a_latch;
    logic [DECIM_W-1:0] r_decim_cnt;
    logic               r_sample_valid;
    logic [31:0]        r_sample_data;
    logic [15:0]        r_orphan_cnt;
    logic [31:0]        r_pair_cnt;

    logic w_is_a;
    logic w_is_b;

    assign w_is_a = adc_valid && (adc_channel == c_ch_a);
    assign w_is_b = adc_valid && (adc_channel == c_ch_b);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_WAIT_A;
            r_a_latch      <= 12'h000;
            r_decim_cnt    <= '0;
            r_sample_valid <= 1'b0;
            r_sample_data  <= 32'h0000_0000;
            r_orphan_cnt   <= 16'h0000;
            r_pair_cnt     <= 32'h0000_0000;
        end else begin
            r_sample_valid <= 1'b0;
            if (!enable) begin
                // Discard any half-formed pair so the first pair after
                // re-enable is emitted from a clean decimation phase.
                r_state     <= S_WAIT_A;
                r_decim_cnt <= '0;
            end else begin
                case (r_state)
                    S_WAIT_A: begin
                        if (w_is_a) begin
                            r_a_latch <= adc_data;
                            r_state   <= S_WAIT_B;
                        end
                    end
                    S_WAIT_B: begin
                        if (w_is_b) begin
                            r_state <= S_WAIT_A;
                            if (r_decim_cnt == '0) begin
                                r_sample_data  <= {4'h0, adc_data, 4'h0, r_a_latch};
                                r_sample_valid <= 1'b1;
                                r_pair_cnt     <= r_pair_cnt + 32'd1;
                                r_decim_cnt    <= decim;
                            end else begin
                                r_decim_cnt <= r_decim_cnt - c_decim_one;
                            end
                        end else if (w_is_a) begin
                            r_a_latch <= adc_data;
                            if (r_orphan_cnt != 16'hFFFF) begin
                                r_orphan_cnt <= r_orphan_cnt + 16'd1;
                            end
                        end
                    end
                    default: r_state <= S_WAIT_A;
                endcase
            end
        end
    end

    assign sample_valid = r_sample_valid;
    assign sample_data  = r_sample_data;
    assign orphan_cnt   = r_orphan_cnt;
    assign pair_cnt     = r_pair_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_pair_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_pair_packer
// Brief    : Scoreboard bench for adc_pair_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_pair_packer;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] decim;
    logic        adc_valid;
    logic [4:0]  adc_channel;
    logic [11:0] adc_data;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic [15:0] orphan_cnt;
    logic [31:0] pair_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] r_exp_q[$];

    adc_pair_packer #(.CH_A(1), .CH_B(2), .DECIM_W(16)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .decim        (decim),
        .adc_valid    (adc_valid),
        .adc_channel  (adc_channel),
        .adc_data     (adc_data),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .orphan_cnt   (orphan_cnt),
        .pair_cnt     (pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && sample_valid) begin
            check("sb_pending", 32'(r_exp_q.size() > 0), 32'd1);
            if (r_exp_q.size() > 0) begin
                check("sb_data", sample_data, r_exp_q.pop_front());
            end
        end
    end

    task automatic beat(input logic [4:0] ch, input logic [11:0] data);
        adc_valid   = 1'b1;
        adc_channel = ch;
        adc_data    = data;
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b1;
        decim       = 16'd0;
        adc_valid   = 1'b0;
        adc_channel = 5'd0;
        adc_data    = 12'h000;
        idle(2);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_data", sample_data, 32'h0);
        check("rst_orphan", 32'(orphan_cnt), 32'd0);
        check("rst_pairs", pair_cnt, 32'd0);
        reset_n = 1'b1;
        idle(1);

        // Basic pairing with one-cycle latency
        r_exp_q.push_back(32'h0ABC_0123);
        beat(5'd1, 12'h123);
        beat(5'd2, 12'hABC);
        @(negedge clk);
        check("pair_latency", 32'(sample_valid), 32'd1);
        idle(3);
        check("pair_cnt1", pair_cnt, 32'd1);
        check("pair_drain", 32'(r_exp_q.size()), 32'd0);

        // Decimation by 3
        do_reset();
        decim = 16'd2;
        r_exp_q.push_back(32'h0101_0001);
        r_exp_q.push_back(32'h0104_0004);
        r_exp_q.push_back(32'h0107_0007);
        for (int n = 1; n <= 7; n++) begin
            beat(5'd1, 12'(n));
            beat(5'd2, 12'(12'h100 + n));
        end
        idle(3);
        check("decim_pairs", pair_cnt, 32'd3);
        check("decim_drain", 32'(r_exp_q.size()), 32'd0);

        // Orphan overwrite and foreign channel
        do_reset();
        decim = 16'd0;
        r_exp_q.push_back(32'h0444_0222);
        beat(5'd1, 12'h111);
        beat(5'd1, 12'h222);
        beat(5'd5, 12'h333);
        beat(5'd2, 12'h444);
        idle(3);
        check("orphan_cnt1", 32'(orphan_cnt), 32'd1);
        beat(5'd2, 12'h555);
        idle(3);
        check("lone_b_pairs", pair_cnt, 32'd1);
        check("orphan_drain", 32'(r_exp_q.size()), 32'd0);

        // Orphan counter saturation
        do_reset();
        adc_valid   = 1'b1;
        adc_channel = 5'd1;
        adc_data    = 12'h0F0;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        adc_valid = 1'b0;
        check("orphan_sat", 32'(orphan_cnt), 32'h0000_FFFF);
        check("sat_pairs", pair_cnt, 32'd0);

        // Enable flush discards the half pair
        do_reset();
        beat(5'd1, 12'h0AA);
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        beat(5'd2, 12'h0BB);
        idle(3);
        check("flush_no_emit", pair_cnt, 32'd0);
        r_exp_q.push_back(32'h0002_0001);
        beat(5'd1, 12'h001);
        beat(5'd2, 12'h002);
        idle(3);
        check("flush_resume", pair_cnt, 32'd1);
        check("flush_drain", 32'(r_exp_q.size()), 32'd0);

        // Asynchronous reset mid-pair
        r_exp_q.push_back(32'h0022_0011);
        beat(5'd1, 12'h011);
        beat(5'd2, 12'h022);
        idle(3);
        beat(5'd1, 12'h033);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_data", sample_data, 32'h0);
        check("arst_pairs", pair_cnt, 32'd0);
        check("arst_valid", 32'(sample_valid), 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        beat(5'd2, 12'h044);
        idle(3);
        check("arst_no_emit", pair_cnt, 32'd0);
        check("arst_drain", 32'(r_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
